// File: rtl/td4_pkg.sv
// ----------------------------------------------------------------------------
// td4_pkg
// Shared definitions for the TD4 4-bit CPU controller:
//   - state_e   : two-phase FSM states (FETCH / EXEC)
//   - OP_*      : 4-bit opcode constants (instr[7:4])
//   - SEL_*     : register-file selector codes, {select_b, select_a}
//   - isAdd()   : true for the two opcodes that update carry from the adder
// ----------------------------------------------------------------------------
package td4_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_e;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0001;
    localparam logic [3:0] OP_MOV_A_C  = 4'b0010;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_MOV_B_C  = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_MOV_D_B  = 4'b1001;
    localparam logic [3:0] OP_MOV_D_IM = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic isAdd(input logic [3:0] op);
        return (op == OP_ADD_A_IM) || (op == OP_ADD_B_IM);
    endfunction

endpackage

// File: rtl/td4_decoder.sv
// ----------------------------------------------------------------------------
// td4_decoder
// Purely combinational instruction decoder. Translates the latched
// instruction word into datapath controls; the controller gates these with
// the EXEC phase, so this block does not know about timing.
// Ports:
//   ir_i           [7:0] latched instruction, [7:4] opcode, [3:0] immediate
//   carry_i              current carry flag (for JNC)
//   sel_o          [1:0] register selector {select_b, select_a}
//   zero_src_o           force adder register operand to zero
//   imm_o          [3:0] adder immediate operand
//   load_o         [3:0] write enables, bit n = register n (A,B,C,D)
//   jump_taken_o         PC loads the immediate instead of incrementing
//   carry_update_o       carry takes the adder carry-out (else cleared)
// ----------------------------------------------------------------------------
module td4_decoder
    import td4_pkg::*;
(
    input  logic [7:0] ir_i,
    input  logic       carry_i,
    output logic [1:0] sel_o,
    output logic       zero_src_o,
    output logic [3:0] imm_o,
    output logic [3:0] load_o,
    output logic       jump_taken_o,
    output logic       carry_update_o
);

    logic [3:0] opcode;
    logic [3:0] immField;

    assign opcode   = ir_i[7:4];
    assign immField = ir_i[3:0];

    // Register-to-register moves use imm 0 so the adder passes the selected
    // register through unchanged; unknown opcodes fall into the NOP default.
    always_comb begin
        sel_o          = SEL_A;
        zero_src_o     = 1'b0;
        imm_o          = 4'h0;
        load_o         = 4'b0000;
        jump_taken_o   = 1'b0;
        carry_update_o = isAdd(opcode);
        case (opcode)
            OP_ADD_A_IM: begin sel_o = SEL_A; imm_o = immField; load_o = 4'b0001; end
            OP_ADD_B_IM: begin sel_o = SEL_B; imm_o = immField; load_o = 4'b0010; end
            OP_MOV_A_B:  begin sel_o = SEL_B; load_o = 4'b0001; end
            OP_MOV_B_A:  begin sel_o = SEL_A; load_o = 4'b0010; end
            OP_MOV_A_IM: begin zero_src_o = 1'b1; imm_o = immField; load_o = 4'b0001; end
            OP_MOV_B_IM: begin zero_src_o = 1'b1; imm_o = immField; load_o = 4'b0010; end
            OP_MOV_A_C:  begin sel_o = SEL_C; load_o = 4'b0001; end
            OP_MOV_B_C:  begin sel_o = SEL_C; load_o = 4'b0010; end
            OP_MOV_D_B:  begin sel_o = SEL_B; load_o = 4'b1000; end
            OP_MOV_D_IM: begin zero_src_o = 1'b1; imm_o = immField; load_o = 4'b1000; end
            OP_JMP:      begin imm_o = immField; jump_taken_o = 1'b1; end
            OP_JNC:      begin imm_o = immField; jump_taken_o = ~carry_i; end
            default:     begin end
        endcase
    end

endmodule

// File: rtl/td4_controller.sv
// ----------------------------------------------------------------------------
// td4_controller
// Two-phase (FETCH/EXEC) controller for the TD4 4-bit CPU. FETCH latches the
// ROM word into IR; EXEC drives the datapath controls for one cycle and
// updates PC and carry at its end.
// Optional build macro: TD4_SINGLE_STEP_EN adds input 'step'; FETCH then
// waits for step==1 before latching, giving one instruction per pulse.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   instr        [7:0]   ROM word at address pc
//   carry_in             carry-out of the external adder
//   pc           [3:0]   program counter / ROM address
//   imm          [3:0]   adder immediate operand
//   select_a, select_b   register selector {select_b, select_a}
//   zero_src             force adder register operand to 0
//   load0..load3         write enables for A, B, C, D
//   carry                carry flag
//   step                 (TD4_SINGLE_STEP_EN only) advance from FETCH
// ----------------------------------------------------------------------------
module td4_controller
    import td4_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       carry_in,
    output logic [3:0] pc,
    output logic [3:0] imm,
    output logic       select_a,
    output logic       select_b,
    output logic       zero_src,
    output logic       load0,
    output logic       load1,
    output logic       load2,
    output logic       load3,
    output logic       carry
`ifdef TD4_SINGLE_STEP_EN
    ,
    input  logic       step
`endif
);

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic       carry_q, carry_d;
    logic [7:0] ir_q, ir_d;

    logic       advance;
    logic       isExec;
    logic [1:0] decSel;
    logic       decZero;
    logic [3:0] decImm;
    logic [3:0] decLoad;
    logic       decJump;
    logic       decCarryUpd;

`ifdef TD4_SINGLE_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    td4_decoder uDecoder (
        .ir_i           (ir_q),
        .carry_i        (carry_q),
        .sel_o          (decSel),
        .zero_src_o     (decZero),
        .imm_o          (decImm),
        .load_o         (decLoad),
        .jump_taken_o   (decJump),
        .carry_update_o (decCarryUpd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            carry_q <= 1'b0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            carry_q <= carry_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        carry_d = carry_q;
        ir_d    = ir_q;
        case (state_q)
            FETCH: begin
                if (advance) begin
                    ir_d    = instr;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = decJump ? ir_q[3:0] : pc_q + 4'd1;
                carry_d = decCarryUpd ? carry_in : 1'b0;
            end
            default: state_d = FETCH;
        endcase
    end

    assign isExec = (state_q == EXEC);

    // Loads are also masked by reset so a register file clocked on the same
    // edge never captures the result of an instruction that reset aborts.
    assign select_a = isExec & decSel[0];
    assign select_b = isExec & decSel[1];
    assign zero_src = isExec & decZero;
    assign imm      = isExec ? decImm : 4'h0;
    assign load0    = isExec & ~reset & decLoad[0];
    assign load1    = isExec & ~reset & decLoad[1];
    assign load2    = isExec & ~reset & decLoad[2];
    assign load3    = isExec & ~reset & decLoad[3];
    assign pc       = pc_q;
    assign carry    = carry_q;

endmodule

// File: tb/tb_td4_controller.sv
// ----------------------------------------------------------------------------
// tb_td4_controller
// Directed program for td4_controller. The stimulus side drives one cycle at
// a time and queues the output vector expected for that cycle; a monitor
// samples the DUT on the falling edge and compares against the queue head.
// Vector layout: {pc, imm, select_b, select_a, zero_src, load3..load0, carry}
// ----------------------------------------------------------------------------
module tb_td4_controller;

    typedef struct {
        logic [15:0] vec;
        string       name;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic       carry_in;
    logic       step;
    logic [3:0] pc;
    logic [3:0] imm;
    logic       select_a;
    logic       select_b;
    logic       zero_src;
    logic       load0;
    logic       load1;
    logic       load2;
    logic       load3;
    logic       carry;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    td4_controller #(.RESET_PC(4'h0)) dut (
        .clk      (clk),
        .reset    (reset),
        .instr    (instr),
        .carry_in (carry_in),
        .pc       (pc),
        .imm      (imm),
        .select_a (select_a),
        .select_b (select_b),
        .zero_src (zero_src),
        .load0    (load0),
        .load1    (load1),
        .load2    (load2),
        .load3    (load3),
        .carry    (carry)
`ifdef TD4_SINGLE_STEP_EN
        ,
        .step     (step)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [3:0] p, input logic [3:0] im,
                                       input logic [1:0] sel, input logic z,
                                       input logic [3:0] ld, input logic c);
        return {p, im, sel, z, ld, c};
    endfunction

    // Compare one sampled DUT vector against the head of the scoreboard.
    task automatic checkOutput(input logic [15:0] act);
        exp_t e;
        e = expQ.pop_front();
        assertCount++;
        if (act !== e.vec) begin
            failCount++;
            $display("[TB] FAIL %s: got pc=%h imm=%h sel=%b z=%b ld=%b c=%b, expected pc=%h imm=%h sel=%b z=%b ld=%b c=%b",
                     e.name, act[15:12], act[11:8], act[7:6], act[5], act[4:1], act[0],
                     e.vec[15:12], e.vec[11:8], e.vec[7:6], e.vec[5], e.vec[4:1], e.vec[0]);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0)
            checkOutput({pc, imm, select_b, select_a, zero_src, load3, load2, load1, load0, carry});
    end

    // Drive inputs for one cycle just after the rising edge and queue the
    // output vector expected during that cycle.
    task automatic applyStimulus(input logic rst, input logic [7:0] ins, input logic cin,
                                 input logic stp, input logic [15:0] expVec, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        reset    = rst;
        instr    = ins;
        carry_in = cin;
        step     = stp;
        e.vec    = expVec;
        e.name   = name;
        expQ.push_back(e);
    endtask

    // One FETCH cycle followed by one EXEC cycle; pc/carry hold across both.
    task automatic runInstr(input logic [7:0] ins, input logic cin, input logic rstInExec,
                            input logic [3:0] p, input logic c, input logic [3:0] im,
                            input logic [1:0] sel, input logic z, input logic [3:0] ld,
                            input string name);
        applyStimulus(1'b0, ins, 1'b0, 1'b1, mk(p, 4'h0, 2'b00, 1'b0, 4'b0000, c), {name, "_fetch"});
        applyStimulus(rstInExec, 8'h00, cin, 1'b1, mk(p, im, sel, z, ld, c), {name, "_exec"});
    endtask

    initial begin
        reset    = 1'b1;
        instr    = 8'h00;
        carry_in = 1'b0;
        step     = 1'b1;

        applyStimulus(1'b1, 8'h00, 1'b0, 1'b1, mk(4'h0, 4'h0, 2'b00, 1'b0, 4'b0000, 1'b0), "reset");

        //        instr  cin  rst  pc    c     imm   sel    z     loads
        runInstr(8'h13, 1'b0, 1'b0, 4'h0, 1'b0, 4'h3, 2'b00, 1'b1, 4'b0001, "mov_a_im3");
        runInstr(8'h09, 1'b0, 1'b0, 4'h1, 1'b0, 4'h9, 2'b00, 1'b0, 4'b0001, "add_a_9");
        runInstr(8'h08, 1'b1, 1'b0, 4'h2, 1'b0, 4'h8, 2'b00, 1'b0, 4'b0001, "add_a_8");
        runInstr(8'hE5, 1'b0, 1'b0, 4'h3, 1'b1, 4'h5, 2'b00, 1'b0, 4'b0000, "jnc_not_taken");
        runInstr(8'hE5, 1'b0, 1'b0, 4'h4, 1'b0, 4'h5, 2'b00, 1'b0, 4'b0000, "jnc_taken");
        runInstr(8'h51, 1'b1, 1'b0, 4'h5, 1'b0, 4'h1, 2'b01, 1'b0, 4'b0010, "add_b_1");
        runInstr(8'h51, 1'b0, 1'b1, 4'h6, 1'b1, 4'h1, 2'b01, 1'b0, 4'b0000, "reset_in_exec");
        runInstr(8'h40, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'b00, 1'b0, 4'b0010, "mov_b_a");
        runInstr(8'h30, 1'b0, 1'b0, 4'h1, 1'b0, 4'h0, 2'b01, 1'b0, 4'b0001, "mov_a_b");
        runInstr(8'hFA, 1'b0, 1'b0, 4'h2, 1'b0, 4'hA, 2'b00, 1'b0, 4'b0000, "jmp_a");
        runInstr(8'h20, 1'b0, 1'b0, 4'hA, 1'b0, 4'h0, 2'b10, 1'b0, 4'b0001, "mov_a_c");
        runInstr(8'h60, 1'b0, 1'b0, 4'hB, 1'b0, 4'h0, 2'b10, 1'b0, 4'b0010, "mov_b_c");
        runInstr(8'h77, 1'b0, 1'b0, 4'hC, 1'b0, 4'h7, 2'b00, 1'b1, 4'b0010, "mov_b_im7");
        runInstr(8'h8F, 1'b0, 1'b0, 4'hD, 1'b0, 4'h0, 2'b00, 1'b0, 4'b0000, "nop_1000");
        runInstr(8'hB6, 1'b0, 1'b0, 4'hE, 1'b0, 4'h6, 2'b00, 1'b1, 4'b1000, "mov_d_im6");
        runInstr(8'hC3, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 2'b00, 1'b0, 4'b0000, "nop_at_f");
        runInstr(8'h90, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 2'b01, 1'b0, 4'b1000, "mov_d_b");
        runInstr(8'h0F, 1'b1, 1'b0, 4'h1, 1'b0, 4'hF, 2'b00, 1'b0, 4'b0001, "add_a_f");
        runInstr(8'h12, 1'b0, 1'b0, 4'h2, 1'b1, 4'h2, 2'b00, 1'b1, 4'b0001, "mov_clears_c");
        runInstr(8'hF3, 1'b0, 1'b0, 4'h3, 1'b0, 4'h3, 2'b00, 1'b0, 4'b0000, "jmp_self_1");
        runInstr(8'hF3, 1'b0, 1'b0, 4'h3, 1'b0, 4'h3, 2'b00, 1'b0, 4'b0000, "jmp_self_2");

`ifdef TD4_SINGLE_STEP_EN
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 8'h15, 1'b0, 1'b0, mk(4'h3, 4'h0, 2'b00, 1'b0, 4'b0000, 1'b0), "step_hold");
        applyStimulus(1'b0, 8'h15, 1'b0, 1'b1, mk(4'h3, 4'h0, 2'b00, 1'b0, 4'b0000, 1'b0), "step_pulse");
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, mk(4'h3, 4'h5, 2'b00, 1'b1, 4'b0001, 1'b0), "step_exec");
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 8'h15, 1'b0, 1'b0, mk(4'h4, 4'h0, 2'b00, 1'b0, 4'b0000, 1'b0), "step_after");
`else
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, mk(4'h3, 4'h0, 2'b00, 1'b0, 4'b0000, 1'b0), "final_fetch");
`endif

        // Let the monitor drain; anything left over is a missed comparison.
        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/td4_controller.md
TD4_CONTROLLER -- requirements
Module: td4_controller

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 4'h0, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: instr  input  8  ROM word at address pc; [7:4] opcode, [3:0] immediate.
REQ-005 Port: carry_in  input  1  carry-out of the external adder (selector output + imm).
REQ-006 Port: pc  output  4  program counter, ROM address.
REQ-007 Port: imm  output  4  adder immediate operand.
REQ-008 Port: select_a, select_b  output  1 each  register-file selector; {select_b,select_a} 00=A, 01=B, 10=C, 11=D.
REQ-009 Port: zero_src  output  1  forces the adder register operand to 0.
REQ-010 Port: load0..load3  output  1 each  write enables for A, B, C, D.
REQ-011 Port: carry  output  1  carry flag.

Function
REQ-012 The FSM SHALL have states FETCH and EXEC, alternating one cycle each, so one instruction completes every 2 cycles.
REQ-013 In FETCH, instr SHALL be latched into an internal IR; all load outputs SHALL be 0.
REQ-014 In EXEC, selects, zero_src, imm and exactly one load (or none) SHALL be driven from IR for that single cycle.
REQ-015 Decode: 0000 ADD A,Im (sel A, load0); 0101 ADD B,Im (sel B, load1).
REQ-016 Decode: 0011 MOV A,B (sel B, imm 0, load0); 0100 MOV B,A (sel A, imm 0, load1).
REQ-017 Decode: 0001 MOV A,Im (zero_src, load0); 0111 MOV B,Im (zero_src, load1).
REQ-018 Decode: 0010 MOV A,C (sel C, imm 0, load0); 0110 MOV B,C (sel C, imm 0, load1).
REQ-019 Decode: 1001 MOV D,B (sel B, imm 0, load3); 1011 MOV D,Im (zero_src, load3).
REQ-020 Decode: 1111 JMP Im; 1110 JNC Im, jump only when carry==0; neither asserts any load.
REQ-021 All other opcodes SHALL be NOPs: no load, PC increments.
REQ-022 At EXEC end, pc SHALL become imm for a taken jump, otherwise pc+1 mod 16 (4'hF wraps to 4'h0).
REQ-023 At EXEC end, carry SHALL take carry_in for ADD opcodes and SHALL be cleared to 0 for every other opcode, jumps included.
REQ-024 Outside EXEC, select_a, select_b and zero_src SHALL be 0 and imm SHALL be 4'h0.
REQ-025 Jump-to-self (JMP imm==pc) SHALL loop indefinitely with no special handling.

Reset
REQ-026 On reset the block SHALL set state=FETCH, pc=RESET_PC, carry=0, IR=8'h00, and all loads, selects and zero_src to 0 on the next edge.
REQ-027 Reset asserted during EXEC SHALL suppress that instruction's PC and carry update.
REQ-028 Reset SHALL take priority over every other event.

Configuration
REQ-029 With macro TD4_SINGLE_STEP_EN defined, the block SHALL add input step (1 bit).
REQ-030 With TD4_SINGLE_STEP_EN, FETCH SHALL hold (no IR latch, no advance) until step==1 is sampled, giving one instruction per step pulse.
REQ-031 Without TD4_SINGLE_STEP_EN, the step port SHALL be absent and FETCH SHALL always advance.

Structure
REQ-032 A shared package td4_pkg SHALL hold the opcode constants, the state enum and the select-code constants (SEL_A..SEL_D).
REQ-033 Decode SHALL be a combinational sub-module td4_decoder (IR, carry -> selects, zero_src, imm, loads, jump_taken, carry_update); FSM, PC and carry SHALL live in td4_controller.

Verification
REQ-034 Reset -> pc=0, carry=0, all loads 0; then instr=8'h13 (MOV A,3) -> EXEC cycle shows zero_src=1, imm=3, load0=1.
REQ-035 Program ADD A,9 then ADD A,8 with carry_in=0 then 1 -> carry 0 then 1; the next JNC 5 is not taken (pc=3); a later JNC 5 after carry 0 gives pc=5.
REQ-036 JMP 4'hA from pc=2 -> pc=A, no load asserted; NOP at pc=F -> pc wraps to 0.
REQ-037 Reset asserted in EXEC of ADD B,1 at pc=6 -> load1 not sampled, pc=RESET_PC, carry=0.
REQ-038 TD4_SINGLE_STEP_EN build with step held 0 for 10 cycles -> pc unchanged; a one-cycle step pulse -> exactly one instruction executes.
REQ-039 Opcode 1000 (NOP) and MOV D,B -> NOP: no loads, pc+1; MOV D,B: sel=01, load3=1 for one cycle.
